// File: rtl/shiftadd_mul_serialized.sv
// shiftadd_mul_serialized
// Bit-serial shift-add multiplier, one multiplier bit per clock. The product is
// held under a valid/ready handshake and zero-extended to 64 bits.
// Optional build macro SHIFTADD_MUL_EARLY_EXIT_EN:
//   defined   -> MUL stops once the remaining multiplier bits are all zero
//                (data-dependent latency)
//   undefined -> MUL always runs OP_WIDTH cycles (constant-time, default)
module shiftadd_mul_serialized #(
   parameter int OP_WIDTH = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [OP_WIDTH-1:0] a_i,
   input  logic [OP_WIDTH-1:0] b_i,
   input  logic                ready_i,
   output logic                busy_o,
   output logic                valid_o,
   output logic [63:0]         result_o
);

   localparam int PW   = 2 * OP_WIDTH;
   localparam int IDXW = $clog2(OP_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PW-1:0]       acc_q;
   logic [PW-1:0]       mcand_q;
   logic [OP_WIDTH-1:0] mplier_q;
   logic [IDXW-1:0]     idx_q;
   logic                mul_last;

`ifdef SHIFTADD_MUL_EARLY_EXIT_EN
   // Stop once no set multiplier bits remain after this cycle's bit; this
   // also covers b=0, which leaves MUL on its first edge.
   assign mul_last = ((mplier_q >> 1) == '0);
`else
   // Constant-time: always consume all OP_WIDTH multiplier bits.
   assign mul_last = (idx_q == IDXW'(OP_WIDTH - 1));
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; any unused encoding falls back to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i)  state_d = MUL;
         MUL:     if (mul_last) state_d = DONE;
         DONE:    if (ready_i)  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Datapath: latch operands on start, accumulate and shift while in MUL.
   // acc_q is left alone in DONE so the result stays stable under back-pressure.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         idx_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  mcand_q  <= PW'(a_i);
                  mplier_q <= b_i;
                  acc_q    <= '0;
                  idx_q    <= '0;
               end
            end
            MUL: begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               idx_q    <= idx_q + IDXW'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from state only, so reset clears them immediately
   always_comb begin
      busy_o   = (state_q != IDLE);
      valid_o  = (state_q == DONE);
      result_o = '0;
      if (state_q == DONE) result_o = 64'(acc_q);
   end

endmodule
